mem_resp_queue: RTL and testbench
=================================

// Module: mem_resp_queue
// PURPOSE
//  Parametrised successor to the single-entry MEM stage: in-order queue between EX and WB that
//  allows up to DEPTH outstanding data-cache requests. Captures each load/store as it leaves EX,
//  matches in-order data_ok responses to the oldest unfinished memory entry, aligns load data
//  (lb/lbu/lh/lhu/lw/lwl/lwr), retires in program order to WB, forwards pending results to
//  ID for interlocks, and drains stray responses after a pipeline flush.
// PARAMETERS
//  DEPTH  4  queue entries = max outstanding requests (power of 2, >=2)
//  PTR_W  $clog2(DEPTH)  pointer width (derived, do not override)
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  enq_valid    in   1   EX presents an instruction
//  enq_ready    out  1   queue accepts; EX must not issue a cache request when low
//  enq_mem      in   1   entry waits for data_ok (load or store)
//  enq_ld_type  in   7   one-hot {lb,lbu,lh,lhu,lw,lwl,lwr}; all-zero for store/non-mem
//  enq_offset   in   2   address[1:0]
//  enq_rt       in   32  rt value (lwl/lwr merge)
//  enq_alu_res  in   32  result for non-load entries
//  enq_gr_we    in   1   writes GPR
//  enq_dest     in   5   destination GPR
//  enq_pc       in   32  PC
//  data_ok      in   1   one in-order cache response (load data or store ack)
//  rdata        in   32  load data, valid with data_ok
//  flush        in   1   exception/eret: discard all entries
//  deq_valid    out  1   head entry complete
//  deq_ready    in   1   WB accepts
//  deq_result   out  32  final result;  deq_gr_we out 1;  deq_dest out 5;  deq_pc out 32
//  q_reg        in   5   ID register being looked up
//  q_hit        out  1   some valid entry with gr_we writes q_reg (q_reg!=0)
//  q_done       out  1   youngest such entry is complete
//  q_data       out  32  result of youngest such entry (valid when q_hit&q_done)
//  proto_err    out  1   sticky: data_ok with no outstanding request
// BEHAVIOUR
//  - Reset: all entries invalid, head=tail=0, drain=0, proto_err=0; deq_valid=0, q_hit=0,
//    enq_ready=1; data outputs 0 via valid-masking.
//  - enq_ready = !full && (drain==0); registered-state only, no path from deq_ready.
//  - Enq fire: write entry at tail, tail++ (mod DEPTH). done=!enq_mem; non-mem result=enq_alu_res.
//  - data_ok: completes oldest valid entry with mem&!done (priority search from head, wrap
//    aware); result = aligned load per ld_type/offset, store entries result=0. Same-cycle enq
//    of a new mem entry is never the target (request issued that cycle cannot return).
//  - Alignment: lb/lbu byte at offset, sign/zero ext; lh/lhu half at offset[1]; lw whole;
//    lwl off0..3 = {rd[7:0],rt[23:0]},{rd[15:0],rt[15:0]},{rd[23:0],rt[7:0]},rd;
//    lwr off0..3 = rd,{rt[31:24],rd[31:8]},{rt[31:16],rd[31:16]},{rt[31:8],rd[31:24]}.
//  - deq_valid = head valid & done; fire frees head, head++. Enq and deq same cycle legal,
//    including full (enq_ready low that cycle; no simultaneous enq at full).
//  - Latency: non-mem entry visible at deq the cycle after enq; load visible cycle after data_ok.
//  - Outstanding count = valid mem entries not done. flush: invalidate all, head=tail=0,
//    drain <= outstanding (minus 1 if data_ok same cycle; plus 1 if enq_valid&enq_mem same
//    cycle - that enq is dropped). While drain>0 each data_ok decrements drain, is discarded.
//  - flush has priority over enq, deq and data_ok completion; deq_valid forced 0 that cycle.
//  - data_ok with outstanding==0 and drain==0: ignored, proto_err<=1 until reset.
//  - Query: combinational over valid entries, youngest (closest to tail) match wins.
// STRUCTURE
//  - Shared pkg (mycpu.h): LD_TYPE one-hot bit positions, LD_TYPE_W=7, entry field widths.
//  - Sub-module load_align (comb: ld_type, offset, rdata, rt -> result), reused by WB forwarding.
//  - Storage: per-entry registers (not RAM) since query reads all entries in parallel.
// TESTING
//  1 enq lw@off0, lbu@off3, add(alu=5); data_ok rd=0x80FF_1234, then 0xAB00_0000; deq_ready=1
//    -> results 0x80FF1234, 0x000000AB, 5 in order, non-mem held until prior loads done.
//  2 fill 4 loads without data_ok -> enq_ready=0; one data_ok+deq same cycle -> enq_ready=1 next.
//  3 lwl off1 rt=0x1122_3344 rd=0xAABB_CCDD -> 0xCCDD_3344; lwr off2 same -> 0x1122_AABB;
//    lh off2 rd=0x8001_0000 -> 0xFFFF_8001.
//  4 3 loads outstanding, flush with data_ok same cycle -> drain=2, enq_ready=0; 2 data_ok
//    discarded, nothing dequeued; enq_ready=1 after second; new load completes correctly.
//  5 dest 8 pending load (not done) and older done add to 8 -> q_hit=1,q_done=0; data_ok
//    rd=7 -> q_done=1,q_data=7; data_ok at reset idle -> proto_err=1 sticky.
//  6 wrap: 10 enq/deq pairs through DEPTH=4 with random deq_ready -> order and data preserved.

Source files
------------

// File: rtl/mem_resp_queue_pkg.sv
// Purpose: shared types for the EX->WB memory response queue (load types, entry layout).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_resp_queue_pkg;

    // One-hot load type, MSB first: {lb, lbu, lh, lhu, lw, lwl, lwr}; all-zero = store/non-mem
    localparam int LD_TYPE_W = 7;
    localparam int LD_LB     = 6;
    localparam int LD_LBU    = 5;
    localparam int LD_LH     = 4;
    localparam int LD_LHU    = 3;
    localparam int LD_LW     = 2;
    localparam int LD_LWL    = 1;
    localparam int LD_LWR    = 0;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OFF_W  = 2;

    typedef logic [LD_TYPE_W-1:0] ld_type_t;

    typedef struct packed {
        logic              mem;      // waits for a data_ok
        logic              done;     // result final, may retire
        ld_type_t          ld_type;
        logic [OFF_W-1:0]  offset;
        logic [DATA_W-1:0] rt;
        logic [DATA_W-1:0] result;
        logic              gr_we;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] pc;
    } entry_t;

endpackage

// File: rtl/mem_resp_queue_load_align.sv
// Purpose: align/extend raw load data by load type and address offset (lwl/lwr merge with rt).
// Latency: combinational.
// Backpressure: none.
// Ports: ld_type (one-hot), offset = addr[1:0], rdata = raw word, rt = merge source,
//        result = aligned value (0 when ld_type is all-zero, i.e. store).
module mem_resp_queue_load_align
    import mem_resp_queue_pkg::*;
(
    input  ld_type_t          ld_type,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] rt,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = '0;
        if (ld_type[LD_LB]) begin
            result = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_type[LD_LBU]) begin
            result = {24'd0, byte_sel};
        end else if (ld_type[LD_LH]) begin
            result = {{16{half_sel[15]}}, half_sel};
        end else if (ld_type[LD_LHU]) begin
            result = {16'd0, half_sel};
        end else if (ld_type[LD_LW]) begin
            result = rdata;
        end else if (ld_type[LD_LWL]) begin
            // Memory bytes fill the register from the top down to the addressed byte
            case (offset)
                2'd0:    result = {rdata[7:0],  rt[23:0]};
                2'd1:    result = {rdata[15:0], rt[15:0]};
                2'd2:    result = {rdata[23:0], rt[7:0]};
                default: result = rdata;
            endcase
        end else if (ld_type[LD_LWR]) begin
            // Memory bytes fill the register from the bottom up from the addressed byte
            case (offset)
                2'd0:    result = rdata;
                2'd1:    result = {rt[31:24], rdata[31:8]};
                2'd2:    result = {rt[31:16], rdata[31:16]};
                default: result = {rt[31:8],  rdata[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/mem_resp_queue.sv
// Purpose: in-order EX->WB queue holding up to DEPTH outstanding data-cache requests.
// Latency: non-mem entry dequeues the cycle after enq; load the cycle after its data_ok.
// Backpressure: enq_ready from registered state only (not full, no drain); deq is valid/ready.
// Ports: enq_* capture an instruction from EX; data_ok/rdata complete the oldest pending mem
//        entry; deq_* retire to WB; q_reg/q_* give ID a forwarding/interlock view; flush
//        discards everything and drains responses still in flight; proto_err is sticky.
module mem_resp_queue
    import mem_resp_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    input  logic                 enq_mem,
    input  ld_type_t             enq_ld_type,
    input  logic [OFF_W-1:0]     enq_offset,
    input  logic [DATA_W-1:0]    enq_rt,
    input  logic [DATA_W-1:0]    enq_alu_res,
    input  logic                 enq_gr_we,
    input  logic [REG_W-1:0]     enq_dest,
    input  logic [DATA_W-1:0]    enq_pc,
    input  logic                 data_ok,
    input  logic [DATA_W-1:0]    rdata,
    input  logic                 flush,
    output logic                 deq_valid,
    input  logic                 deq_ready,
    output logic [DATA_W-1:0]    deq_result,
    output logic                 deq_gr_we,
    output logic [REG_W-1:0]     deq_dest,
    output logic [DATA_W-1:0]    deq_pc,
    input  logic [REG_W-1:0]     q_reg,
    output logic                 q_hit,
    output logic                 q_done,
    output logic [DATA_W-1:0]    q_data,
    output logic                 proto_err
);

    logic [DEPTH-1:0] valid;
    entry_t           ent [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   drain;
    logic             proto_err_q;

    logic             full;
    logic             enq_fire;
    logic             deq_fire;
    logic             head_done;
    logic [PTR_W:0]   outstanding;
    logic             tgt_found;
    logic [PTR_W-1:0] tgt_idx;
    logic             ok_drain;
    logic             ok_complete;
    logic             ok_stray;
    logic [PTR_W:0]   drain_flush;
    logic [DATA_W-1:0] align_res;
    entry_t           new_ent;

    // Entries are allocated in order, so the slot at tail is occupied only when full.
    assign full      = valid[tail];
    assign enq_ready = !full && (drain == '0);
    assign enq_fire  = enq_valid && enq_ready;

    assign head_done = valid[head] && ent[head].done;
    assign deq_valid = head_done && !flush;
    assign deq_fire  = deq_valid && deq_ready;

    assign deq_result = deq_valid ? ent[head].result : '0;
    assign deq_gr_we  = deq_valid ? ent[head].gr_we  : 1'b0;
    assign deq_dest   = deq_valid ? ent[head].dest   : '0;
    assign deq_pc     = deq_valid ? ent[head].pc     : '0;

    assign proto_err = proto_err_q;

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && ent[i].mem && !ent[i].done) begin
                outstanding = outstanding + (PTR_W+1)'(1);
            end
        end
    end

    // Oldest pending mem entry, searched from head so the search wraps naturally.
    always_comb begin
        tgt_found = 1'b0;
        tgt_idx   = head;
        for (int i = 0; i < DEPTH; i++) begin
            if (!tgt_found && valid[head + PTR_W'(i)] && ent[head + PTR_W'(i)].mem &&
                !ent[head + PTR_W'(i)].done) begin
                tgt_found = 1'b1;
                tgt_idx   = head + PTR_W'(i);
            end
        end
    end

    // While draining, no entries can exist (enq is blocked), so drain and targets never overlap.
    assign ok_drain    = data_ok && (drain != '0);
    assign ok_complete = data_ok && (drain == '0) && tgt_found;
    assign ok_stray    = data_ok && (drain == '0) && !tgt_found;

    // Responses still owed after a flush: earlier drain, live requests, and a request issued by
    // an enq accepted this very cycle (its entry is dropped but the cache will still answer),
    // less the response consumed this cycle.
    assign drain_flush = drain + outstanding + (PTR_W+1)'(enq_fire && enq_mem)
                       - (PTR_W+1)'(data_ok && !ok_stray);

    mem_resp_queue_load_align u_align (
        .ld_type (ent[tgt_idx].ld_type),
        .offset  (ent[tgt_idx].offset),
        .rdata   (rdata),
        .rt      (ent[tgt_idx].rt),
        .result  (align_res)
    );

    always_comb begin
        new_ent         = '0;
        new_ent.mem     = enq_mem;
        new_ent.done    = !enq_mem;
        new_ent.ld_type = enq_ld_type;
        new_ent.offset  = enq_offset;
        new_ent.rt      = enq_rt;
        new_ent.result  = enq_mem ? '0 : enq_alu_res;
        new_ent.gr_we   = enq_gr_we;
        new_ent.dest    = enq_dest;
        new_ent.pc      = enq_pc;
    end

    // Youngest matching entry wins: later iterations (closer to tail) overwrite earlier ones.
    always_comb begin
        q_hit  = 1'b0;
        q_done = 1'b0;
        q_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_reg != '0 && valid[head + PTR_W'(i)] && ent[head + PTR_W'(i)].gr_we &&
                ent[head + PTR_W'(i)].dest == q_reg) begin
                q_hit  = 1'b1;
                q_done = ent[head + PTR_W'(i)].done;
                q_data = ent[head + PTR_W'(i)].done ? ent[head + PTR_W'(i)].result : '0;
            end
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (reset) begin
            valid       <= '0;
            head        <= '0;
            tail        <= '0;
            drain       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (ok_stray) begin
                proto_err_q <= 1'b1;
            end
            if (flush) begin
                valid <= '0;
                head  <= '0;
                tail  <= '0;
                drain <= drain_flush;
            end else begin
                if (ok_drain) begin
                    drain <= drain - (PTR_W+1)'(1);
                end
                if (enq_fire) begin
                    valid[tail] <= 1'b1;
                    tail        <= tail + PTR_W'(1);
                end
                if (deq_fire) begin
                    valid[head] <= 1'b0;
                    head        <= head + PTR_W'(1);
                end
            end
        end
    end

    // Entry payload; contents of invalid slots are don't-care, so no reset needed.
    // The completion target is always valid, so it never collides with the enq slot.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            ent[tail] <= new_ent;
        end
        if (ok_complete && !flush) begin
            ent[tgt_idx].done   <= 1'b1;
            ent[tgt_idx].result <= align_res;
        end
    end

endmodule

// File: tb/tb_mem_resp_queue.sv
module tb_mem_resp_queue;

    localparam logic [6:0] LB  = 7'b1000000;
    localparam logic [6:0] LBU = 7'b0100000;
    localparam logic [6:0] LH  = 7'b0010000;
    localparam logic [6:0] LW  = 7'b0000100;
    localparam logic [6:0] LWL = 7'b0000010;
    localparam logic [6:0] LWR = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid, enq_ready, enq_mem, enq_gr_we;
    logic [6:0]  enq_ld_type;
    logic [1:0]  enq_offset;
    logic [31:0] enq_rt, enq_alu_res, enq_pc;
    logic [4:0]  enq_dest;
    logic        data_ok, flush;
    logic [31:0] rdata;
    logic        deq_valid, deq_ready, deq_gr_we;
    logic [31:0] deq_result, deq_pc;
    logic [4:0]  deq_dest;
    logic [4:0]  q_reg;
    logic        q_hit, q_done;
    logic [31:0] q_data;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_resp_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_mem(enq_mem),
        .enq_ld_type(enq_ld_type), .enq_offset(enq_offset), .enq_rt(enq_rt),
        .enq_alu_res(enq_alu_res), .enq_gr_we(enq_gr_we), .enq_dest(enq_dest),
        .enq_pc(enq_pc), .data_ok(data_ok), .rdata(rdata), .flush(flush),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_result(deq_result),
        .deq_gr_we(deq_gr_we), .deq_dest(deq_dest), .deq_pc(deq_pc),
        .q_reg(q_reg), .q_hit(q_hit), .q_done(q_done), .q_data(q_data),
        .proto_err(proto_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic mem, input logic [6:0] lt, input logic [1:0] off,
                       input logic [31:0] rt, input logic [31:0] alu,
                       input logic [4:0] dest, input logic [31:0] pc);
        enq_valid   = 1'b1;
        enq_mem     = mem;
        enq_ld_type = lt;
        enq_offset  = off;
        enq_rt      = rt;
        enq_alu_res = alu;
        enq_gr_we   = 1'b1;
        enq_dest    = dest;
        enq_pc      = pc;
        #1;
        check_eq("enq_ready_before_enq", enq_ready, 1);
        tick();
        enq_valid   = 1'b0;
        enq_mem     = 1'b0;
        enq_ld_type = '0;
    endtask

    task automatic resp(input logic [31:0] rd);
        data_ok = 1'b1;
        rdata   = rd;
        tick();
        data_ok = 1'b0;
        rdata   = '0;
    endtask

    initial begin
        int sent, recvd, cyc;
        reset = 1'b1; enq_valid = 0; enq_mem = 0; enq_ld_type = 0; enq_offset = 0;
        enq_rt = 0; enq_alu_res = 0; enq_gr_we = 0; enq_dest = 0; enq_pc = 0;
        data_ok = 0; rdata = 0; flush = 0; deq_ready = 0; q_reg = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check_eq("rst_deq_valid", deq_valid, 0);
        check_eq("rst_enq_ready", enq_ready, 1);
        check_eq("rst_q_hit", q_hit, 0);
        check_eq("rst_proto_err", proto_err, 0);
        check_eq("rst_deq_result", deq_result, 0);

        // 1: lw, lbu, add; add must wait behind the loads
        enq(1, LW,  2'd0, 0, 0, 5'd2, 32'h100);
        enq(1, LBU, 2'd3, 0, 0, 5'd3, 32'h104);
        enq(0, 7'd0, 2'd0, 0, 32'd5, 5'd4, 32'h108);
        #1;
        check_eq("t1_head_wait", deq_valid, 0);
        resp(32'h80FF_1234);
        #1;
        check_eq("t1_lw_valid", deq_valid, 1);
        check_eq("t1_lw_res", deq_result, 32'h80FF_1234);
        check_eq("t1_lw_dest", deq_dest, 2);
        check_eq("t1_lw_pc", deq_pc, 32'h100);
        deq_ready = 1'b1;
        resp(32'hAB00_0000);
        #1;
        check_eq("t1_lbu_valid", deq_valid, 1);
        check_eq("t1_lbu_res", deq_result, 32'h0000_00AB);
        check_eq("t1_lbu_dest", deq_dest, 3);
        tick();
        check_eq("t1_add_res", deq_result, 5);
        check_eq("t1_add_we", deq_gr_we, 1);
        tick();
        check_eq("t1_empty", deq_valid, 0);
        deq_ready = 1'b0;

        // 2: fill with four loads, then retire with data_ok + deq overlapping
        for (int i = 0; i < 4; i++) enq(1, LW, 2'd0, 0, 0, 5'(i + 1), 32'h200 + 32'(4 * i));
        #1;
        check_eq("t2_full_rdy", enq_ready, 0);
        resp(32'h0000_0011);
        #1;
        check_eq("t2_still_full", enq_ready, 0);
        check_eq("t2_head_res", deq_result, 32'h11);
        deq_ready = 1'b1;
        resp(32'h0000_0022);
        #1;
        check_eq("t2_rdy_after_deq", enq_ready, 1);
        check_eq("t2_second_res", deq_result, 32'h22);
        resp(32'h0000_0033);
        #1;
        check_eq("t2_third_res", deq_result, 32'h33);
        resp(32'h0000_0044);
        #1;
        check_eq("t2_fourth_res", deq_result, 32'h44);
        tick();
        check_eq("t2_empty", deq_valid, 0);
        deq_ready = 1'b0;

        // 3: partial-word loads
        enq(1, LWL, 2'd1, 32'h1122_3344, 0, 5'd5, 32'h300);
        enq(1, LWR, 2'd2, 32'h1122_3344, 0, 5'd6, 32'h304);
        enq(1, LH,  2'd2, 0, 0, 5'd7, 32'h308);
        resp(32'hAABB_CCDD);
        resp(32'hAABB_CCDD);
        resp(32'h8001_0000);
        #1;
        check_eq("t3_lwl", deq_result, 32'hCCDD_3344);
        deq_ready = 1'b1;
        tick();
        check_eq("t3_lwr", deq_result, 32'h1122_AABB);
        tick();
        check_eq("t3_lh", deq_result, 32'hFFFF_8001);
        tick();
        check_eq("t3_empty", deq_valid, 0);
        deq_ready = 1'b0;

        // lb sign extension at offset 1
        enq(1, LB, 2'd1, 0, 0, 5'd9, 32'h30C);
        resp(32'h0000_9000);
        #1;
        check_eq("t3_lb", deq_result, 32'hFFFF_FF90);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;

        // 4: flush with three outstanding and a same-cycle response
        for (int i = 0; i < 3; i++) enq(1, LW, 2'd0, 0, 0, 5'(10 + i), 32'h400 + 32'(4 * i));
        flush = 1'b1;
        deq_ready = 1'b1;
        resp(32'hDEAD_0001);
        flush = 1'b0;
        #1;
        check_eq("t4_drain_rdy", enq_ready, 0);
        check_eq("t4_no_deq0", deq_valid, 0);
        resp(32'hDEAD_0002);
        #1;
        check_eq("t4_drain1_rdy", enq_ready, 0);
        check_eq("t4_no_deq1", deq_valid, 0);
        resp(32'hDEAD_0003);
        #1;
        check_eq("t4_drained_rdy", enq_ready, 1);
        check_eq("t4_no_deq2", deq_valid, 0);
        check_eq("t4_no_proto", proto_err, 0);
        deq_ready = 1'b0;
        enq(1, LW, 2'd0, 0, 0, 5'd13, 32'h500);
        resp(32'hCAFE_F00D);
        #1;
        check_eq("t4_new_valid", deq_valid, 1);
        check_eq("t4_new_res", deq_result, 32'hCAFE_F00D);
        check_eq("t4_new_pc", deq_pc, 32'h500);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;

        // 5: forwarding query, then stray response
        enq(0, 7'd0, 2'd0, 0, 32'h55, 5'd8, 32'h600);
        q_reg = 5'd8;
        #1;
        check_eq("t5_add_hit", q_hit, 1);
        check_eq("t5_add_done", q_done, 1);
        check_eq("t5_add_data", q_data, 32'h55);
        enq(1, LW, 2'd0, 0, 0, 5'd8, 32'h604);
        #1;
        check_eq("t5_ld_hit", q_hit, 1);
        check_eq("t5_ld_pending", q_done, 0);
        resp(32'h0000_0007);
        #1;
        check_eq("t5_ld_done", q_done, 1);
        check_eq("t5_ld_data", q_data, 7);
        q_reg = 5'd0;
        #1;
        check_eq("t5_r0_nohit", q_hit, 0);
        deq_ready = 1'b1;
        tick(); tick();
        deq_ready = 1'b0;
        q_reg = 5'd8;
        #1;
        check_eq("t5_gone_nohit", q_hit, 0);
        resp(32'h1234_5678);
        #1;
        check_eq("t5_proto_set", proto_err, 1);
        check_eq("t5_stray_no_deq", deq_valid, 0);
        tick(); tick();
        check_eq("t5_proto_sticky", proto_err, 1);
        q_reg = 5'd0;

        // 6: ten non-mem entries through the ring with random WB backpressure
        sent = 0; recvd = 0; cyc = 0;
        while (recvd < 10 && cyc < 300) begin
            enq_valid   = (sent < 10);
            enq_mem     = 1'b0;
            enq_gr_we   = 1'b1;
            enq_alu_res = 32'h100 + 32'(sent * 7);
            enq_dest    = 5'(sent + 1);
            deq_ready   = 1'($urandom_range(0, 1));
            #1;
            if (deq_valid && deq_ready) begin
                check_eq("t6_res", deq_result, 32'h100 + 32'(recvd * 7));
                check_eq("t6_dest", deq_dest, 32'(recvd + 1));
                recvd++;
            end
            if (enq_valid && enq_ready) sent++;
            tick();
            cyc++;
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check_eq("t6_count", recvd, 10);
        #1;
        check_eq("t6_empty", deq_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
